// File: rtl/mips_mem_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// Contents: arb_state_e (arbiter FSM states), owner_e (who holds the current
// access), mem_req_t (captured issue request), default widths and starvation limit.
package mips_mem_pkg;

  localparam int ADDR_W_DEF   = 5;
  localparam int DATA_W_DEF   = 32;
  localparam int MAX_WAIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACC_PIPE = 2'd1,
    ACC_DBG  = 2'd2,
    RESP     = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_PIPE = 1'b0,
    OWN_DBG  = 1'b1
  } owner_e;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/arb_wait_ctr.sv
// Saturating starvation counter for the debug port.
// Ports:
//   i_clk    clock
//   i_rst_n  synchronous active-low reset
//   i_inc    count one lost arbitration (ignored once saturated)
//   i_clr    clear the count (wins over i_inc)
//   o_sat    count has reached MAX
module arb_wait_ctr #(
  parameter int MAX = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam int W = $clog2(MAX + 1);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX_V)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_sat = (r_cnt == MAX_V);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data RAM between the MEM pipeline stage and
// a debug/loader port. Each access is issue (1 cycle) then response (1 cycle)
// after a 1-cycle grant in IDLE; the pipeline is stalled while its access is
// pending and debug is forced through after MAX_WAIT lost arbitrations.
// Ports:
//   i_clk, i_rst_n                     clock, synchronous active-low reset
//   i_pipe_req/we/addr/wdata           MEM stage request
//   o_pipe_rdata, o_pipe_stall         MEM stage load data and stall
//   i_dbg_req/we/addr/wdata            debug request (held until ack)
//   o_dbg_rdata, o_dbg_ack             debug read data and completion pulse
//   o_mem_en/we/addr/wdata, i_mem_rdata  RAM side (1-cycle read latency)
// Optional: define DMEM_ARB_STATS_EN to add o_stat_pipe_cnt, o_stat_dbg_cnt,
//   o_stat_stall_cnt saturating 16-bit statistics counters.
//
// state    | meaning
// IDLE     | no access in flight; arbitrate and capture winner's request
// ACC_PIPE | RAM access issued for the pipeline
// ACC_DBG  | RAM access issued for the debug port
// RESP     | RAM read data valid; complete the owner's access
module dmem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pipe_req,
  input  logic              i_pipe_we,
  input  logic [ADDR_W-1:0] i_pipe_addr,
  input  logic [DATA_W-1:0] i_pipe_wdata,
  output logic [DATA_W-1:0] o_pipe_rdata,
  output logic              o_pipe_stall,
  input  logic              i_dbg_req,
  input  logic              i_dbg_we,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_wdata,
  output logic [DATA_W-1:0] o_dbg_rdata,
  output logic              o_dbg_ack,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       o_stat_pipe_cnt,
  output logic [15:0]       o_stat_dbg_cnt,
  output logic [15:0]       o_stat_stall_cnt
`endif
);

  arb_state_e r_state, w_state_nxt;
  owner_e     r_owner, w_owner_nxt;
  mem_req_t   r_issue, w_issue_nxt;

  logic [DATA_W-1:0] r_pipe_rdata;
  logic [DATA_W-1:0] r_dbg_rdata;

  logic w_grant_pipe, w_grant_dbg;
  logic w_wait_sat;
  logic w_in_acc, w_in_resp;
  logic w_pipe_done, w_dbg_done;
  logic w_pipe_rd_resp, w_dbg_rd_resp;

  arb_wait_ctr #(.MAX(MAX_WAIT)) u_wait_ctr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_grant_pipe & i_dbg_req),
    .i_clr   (w_grant_dbg | ~i_dbg_req),
    .o_sat   (w_wait_sat)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_issue_nxt  = r_issue;
    w_grant_pipe = 1'b0;
    w_grant_dbg  = 1'b0;
    case (r_state)
      IDLE: begin
        // Pipe normally wins; debug wins when pipe is quiet or debug has starved.
        if (i_dbg_req && (!i_pipe_req || w_wait_sat)) begin
          w_grant_dbg = 1'b1;
          w_state_nxt = ACC_DBG;
          w_owner_nxt = OWN_DBG;
          w_issue_nxt = '{we: i_dbg_we, addr: i_dbg_addr, wdata: i_dbg_wdata};
        end else if (i_pipe_req) begin
          w_grant_pipe = 1'b1;
          w_state_nxt  = ACC_PIPE;
          w_owner_nxt  = OWN_PIPE;
          w_issue_nxt  = '{we: i_pipe_we, addr: i_pipe_addr, wdata: i_pipe_wdata};
        end
      end
      ACC_PIPE, ACC_DBG: w_state_nxt = RESP;
      RESP:              w_state_nxt = IDLE;
      default:           w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_owner      <= OWN_PIPE;
      r_issue      <= '0;
      r_pipe_rdata <= '0;
      r_dbg_rdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_issue <= w_issue_nxt;
      if (w_pipe_rd_resp) r_pipe_rdata <= i_mem_rdata;
      if (w_dbg_rd_resp)  r_dbg_rdata  <= i_mem_rdata;
    end
  end

  assign w_in_acc       = (r_state == ACC_PIPE) || (r_state == ACC_DBG);
  assign w_in_resp      = (r_state == RESP);
  assign w_pipe_done    = w_in_resp && (r_owner == OWN_PIPE);
  assign w_dbg_done     = w_in_resp && (r_owner == OWN_DBG);
  assign w_pipe_rd_resp = w_pipe_done && !r_issue.we;
  assign w_dbg_rd_resp  = w_dbg_done && !r_issue.we;

  assign o_mem_en    = w_in_acc;
  assign o_mem_we    = w_in_acc && r_issue.we;
  assign o_mem_addr  = r_issue.addr;
  assign o_mem_wdata = r_issue.wdata;

  // Read data is forwarded in the response cycle so the pipeline can consume
  // it as the stall drops; the register keeps it afterwards.
  assign o_pipe_rdata = w_pipe_rd_resp ? i_mem_rdata : r_pipe_rdata;
  assign o_dbg_rdata  = w_dbg_rd_resp ? i_mem_rdata : r_dbg_rdata;

  // Reset is folded in so a held request cannot raise stall/ack during reset.
  assign o_pipe_stall = i_rst_n && i_pipe_req && !w_pipe_done;
  assign o_dbg_ack    = i_rst_n && w_dbg_done;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] r_stat_pipe, r_stat_dbg, r_stat_stall;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_stat_pipe  <= '0;
      r_stat_dbg   <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_grant_pipe && (r_stat_pipe != 16'hFFFF))  r_stat_pipe  <= r_stat_pipe + 16'd1;
      if (w_grant_dbg && (r_stat_dbg != 16'hFFFF))    r_stat_dbg   <= r_stat_dbg + 16'd1;
      if (o_pipe_stall && (r_stat_stall != 16'hFFFF)) r_stat_stall <= r_stat_stall + 16'd1;
    end
  end

  assign o_stat_pipe_cnt  = r_stat_pipe;
  assign o_stat_dbg_cnt   = r_stat_dbg;
  assign o_stat_stall_cnt = r_stat_stall;
`endif

endmodule
